// File: rtl/dc_fetch_queue.sv
// dc_fetch_queue: receiver end of the IF->DC handshake. Buffers fetched
// {jump, pc, inst} beats in a small FIFO and presents the oldest entry to
// issue/rename together with its RV32I field decode. A flush empties it.
module dc_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_valid,
  input  logic [31:0] IF_out_pc,
  input  logic [31:0] IF_out_inst,
  input  logic        IF_out_jump,
  output logic        DC_ready,
  input  logic        flush,
  output logic        dc_valid,
  input  logic        dc_ready,
  output logic [31:0] dc_pc,
  output logic [31:0] dc_inst,
  output logic        dc_jump,
  output logic [6:0]  dc_opcode,
  output logic [4:0]  dc_rd,
  output logic [4:0]  dc_rs1,
  output logic [4:0]  dc_rs2,
  output logic [31:0] dc_imm,
  output logic        dc_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  // Entry layout: {jump, pc, inst}
  logic [64:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          enq;
  logic          deq;
  logic [64:0]   headEntry;

  // Handshake qualification; ready depends on occupancy only, never on dc_ready
  always_comb begin
    DC_ready = (count_q != FullCount);
    dc_valid = (count_q != '0);
    enq      = IF_valid && DC_ready && !flush;
    deq      = dc_valid && dc_ready && !flush;
  end

  // Next-state for pointers and occupancy; flush wins over any handshake
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; reset also scrubs stale contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (enq) begin
      mem_q[wr_ptr_q] <= {IF_out_jump, IF_out_pc, IF_out_inst};
    end
  end

  // Head fields, forced to zero whenever the queue is empty
  always_comb begin
    headEntry = dc_valid ? mem_q[rd_ptr_q] : '0;
    dc_jump   = headEntry[64];
    dc_pc     = headEntry[63:32];
    dc_inst   = headEntry[31:0];
    dc_opcode = dc_inst[6:0];
    dc_rd     = dc_inst[11:7];
    dc_rs1    = dc_inst[19:15];
    dc_rs2    = dc_inst[24:20];
  end

  // RV32I immediate decode and illegal-opcode detection on the head entry
  always_comb begin
    dc_imm     = '0;
    dc_illegal = 1'b0;
    case (dc_opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        dc_imm = {{20{dc_inst[31]}}, dc_inst[31:20]};
      7'b0100011:
        dc_imm = {{20{dc_inst[31]}}, dc_inst[31:25], dc_inst[11:7]};
      7'b1100011:
        dc_imm = {{19{dc_inst[31]}}, dc_inst[31], dc_inst[7],
                  dc_inst[30:25], dc_inst[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        dc_imm = {dc_inst[31:12], 12'b0};
      7'b1101111:
        dc_imm = {{11{dc_inst[31]}}, dc_inst[31], dc_inst[19:12],
                  dc_inst[20], dc_inst[30:21], 1'b0};
      7'b0110011:
        dc_imm = '0;
      default: begin
        dc_imm     = '0;
        dc_illegal = dc_valid;
      end
    endcase
  end

endmodule

// File: tb/tb_dc_fetch_queue.sv
// tb_dc_fetch_queue: directed test of dc_fetch_queue (DEPTH = 4) covering
// reset, fill/backpressure, streaming with pointer wrap, flush, mid-run
// reset and immediate decode.
module tb_dc_fetch_queue;

  logic        clk;
  logic        rst;
  logic        IF_valid;
  logic [31:0] IF_out_pc;
  logic [31:0] IF_out_inst;
  logic        IF_out_jump;
  logic        DC_ready;
  logic        flush;
  logic        dc_valid;
  logic        dc_ready;
  logic [31:0] dc_pc;
  logic [31:0] dc_inst;
  logic        dc_jump;
  logic [6:0]  dc_opcode;
  logic [4:0]  dc_rd;
  logic [4:0]  dc_rs1;
  logic [4:0]  dc_rs2;
  logic [31:0] dc_imm;
  logic        dc_illegal;

  int vectors;
  int miscompares;

  dc_fetch_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .IF_valid   (IF_valid),
    .IF_out_pc  (IF_out_pc),
    .IF_out_inst(IF_out_inst),
    .IF_out_jump(IF_out_jump),
    .DC_ready   (DC_ready),
    .flush      (flush),
    .dc_valid   (dc_valid),
    .dc_ready   (dc_ready),
    .dc_pc      (dc_pc),
    .dc_inst    (dc_inst),
    .dc_jump    (dc_jump),
    .dc_opcode  (dc_opcode),
    .dc_rd      (dc_rd),
    .dc_rs1     (dc_rs1),
    .dc_rs2     (dc_rs2),
    .dc_imm     (dc_imm),
    .dc_illegal (dc_illegal)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every input in one go
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic [31:0] inst, input logic jmp,
                               input logic rdy, input logic fl);
    IF_valid    = v;
    IF_out_pc   = pc;
    IF_out_inst = inst;
    IF_out_jump = jmp;
    dc_ready    = rdy;
    flush       = fl;
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, flag it if it differs
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset DC_ready", 32'(DC_ready), 32'd1);
    checkOutput("reset dc_valid", 32'(dc_valid), 32'd0);
    checkOutput("reset dc_pc", dc_pc, 32'h0);
    checkOutput("reset dc_illegal", 32'(dc_illegal), 32'd0);

    $display("[TB] first beat, no fall-through");
    applyStimulus(1'b1, 32'h0, 32'hFFF00093, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("no fall-through", 32'(dc_valid), 32'd0);
    tick();
    checkOutput("beat0 valid", 32'(dc_valid), 32'd1);
    checkOutput("beat0 opcode", 32'(dc_opcode), 32'h13);
    checkOutput("beat0 rd", 32'(dc_rd), 32'd1);
    checkOutput("beat0 rs1", 32'(dc_rs1), 32'd0);
    checkOutput("beat0 imm", dc_imm, 32'hFFFFFFFF);
    checkOutput("beat0 jump", 32'(dc_jump), 32'd1);

    $display("[TB] fill to full");
    applyStimulus(1'b1, 32'h4, 32'h00100113, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8, 32'h00200193, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("count3 DC_ready", 32'(DC_ready), 32'd1);
    applyStimulus(1'b1, 32'hC, 32'h00300213, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("full DC_ready", 32'(DC_ready), 32'd0);
    checkOutput("full head pc", dc_pc, 32'h0);
    applyStimulus(1'b1, 32'h10, 32'h00400293, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("held-off DC_ready", 32'(DC_ready), 32'd0);
    checkOutput("held-off head pc", dc_pc, 32'h0);
    checkOutput("held-off head stable inst", dc_inst, 32'hFFF00093);

    $display("[TB] drain in order");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("drain DC_ready rises", 32'(DC_ready), 32'd1);
    checkOutput("drain pc1", dc_pc, 32'h4);
    tick();
    checkOutput("drain pc2", dc_pc, 32'h8);
    tick();
    checkOutput("drain pc3", dc_pc, 32'hC);
    tick();
    checkOutput("drain empty", 32'(dc_valid), 32'd0);
    checkOutput("drain empty pc", dc_pc, 32'h0);

    $display("[TB] streaming 16 beats");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(4 * i), 32'h00000013 | (32'(i) << 20),
                    i[0], 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("stream%0d pc", i), dc_pc, 32'h200 + 32'(4 * i));
      checkOutput($sformatf("stream%0d jump", i), 32'(dc_jump), 32'(i[0]));
      checkOutput($sformatf("stream%0d DC_ready", i), 32'(DC_ready), 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("stream end empty", 32'(dc_valid), 32'd0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h30, 32'h00000013, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h34, 32'h00000013, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h38, 32'h00000013, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h40, 32'h00000013, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("flush-cycle head pc", dc_pc, 32'h30);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("post-flush dc_valid", 32'(dc_valid), 32'd0);
    checkOutput("post-flush DC_ready", 32'(DC_ready), 32'd1);
    applyStimulus(1'b1, 32'h100, 32'h00000013, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("post-flush head pc", dc_pc, 32'h100);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("flushed beat dropped", 32'(dc_valid), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 32'h500, 32'h00000013, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h504, 32'h00000013, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-reset dc_valid", 32'(dc_valid), 32'd0);
    checkOutput("mid-reset DC_ready", 32'(DC_ready), 32'd1);

    $display("[TB] immediate decode");
    applyStimulus(1'b1, 32'h600, 32'h0020A423, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("sw imm", dc_imm, 32'd8);
    checkOutput("sw rs1", 32'(dc_rs1), 32'd1);
    checkOutput("sw rs2", 32'(dc_rs2), 32'd2);
    applyStimulus(1'b1, 32'h604, 32'hFE000EE3, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("branch imm", dc_imm, 32'hFFFFFFFC);
    applyStimulus(1'b1, 32'h608, 32'h123452B7, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("lui imm", dc_imm, 32'h12345000);
    checkOutput("lui rd", 32'(dc_rd), 32'd5);
    applyStimulus(1'b1, 32'h60C, 32'h008000EF, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("jal imm", dc_imm, 32'd8);
    checkOutput("jal rd", 32'(dc_rd), 32'd1);
    applyStimulus(1'b1, 32'h610, 32'h002081B3, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("add imm", dc_imm, 32'd0);
    checkOutput("add illegal", 32'(dc_illegal), 32'd0);
    applyStimulus(1'b1, 32'h614, 32'h00000000, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("zero illegal", 32'(dc_illegal), 32'd1);
    checkOutput("zero imm", dc_imm, 32'd0);
    checkOutput("zero still valid", 32'(dc_valid), 32'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("final empty illegal", 32'(dc_illegal), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
